// File: rtl/frame_wr_if.sv
// Pixel-in / memory-bus-out signal bundle for the frame writer.
// master: the frame writer itself. slave: pixel source plus memory controller.
interface frame_wr_if #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned WDATA_WIDTH     = 128
);
  logic                       i_frame_start;
  logic                       i_pix_valid;
  logic [23:0]                i_pix_data;
  logic                       o_pix_ready;
  logic                       i_mbus_wdata_rq;
  logic                       i_mbus_wbusy;
  logic                       i_mbus_wsel;
  logic                       o_mbus_wrq;
  logic [CTRL_ADDR_WIDTH-1:0] o_mbus_waddr;
  logic [WDATA_WIDTH-1:0]     o_mbus_wdata;
  logic                       o_mbus_wready;
  logic                       o_underflow;

  modport master (
    input  i_frame_start, i_pix_valid, i_pix_data,
    input  i_mbus_wdata_rq, i_mbus_wbusy, i_mbus_wsel,
    output o_pix_ready, o_mbus_wrq, o_mbus_waddr, o_mbus_wdata, o_mbus_wready, o_underflow
  );

  modport slave (
    output i_frame_start, i_pix_valid, i_pix_data,
    output i_mbus_wdata_rq, i_mbus_wbusy, i_mbus_wsel,
    input  o_pix_ready, o_mbus_wrq, o_mbus_waddr, o_mbus_wdata, o_mbus_wready, o_underflow
  );
endinterface

// File: rtl/frame_wr_interface.sv
// Frame writer: packs RGB565 pixels into bus words, buffers them in a show-ahead FIFO and
// hands fixed-length bursts to the memory controller at consecutive addresses.
module frame_wr_interface #(
  parameter int unsigned MEM_DQ_WIDTH    = 16,
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned BURST_LENGTH    = 8,
  parameter int unsigned START_ADDRESS   = 0,
  parameter int unsigned BURST_NUM       = 15,
  parameter int unsigned ADDR_STEP       = 128,
  parameter int unsigned FIFO_DEPTH      = 64
) (
  input  logic            i_axi_aclk,
  input  logic            i_rstn,
  frame_wr_if.master      bus
);

  localparam int unsigned WordW    = MEM_DQ_WIDTH * BURST_LENGTH;
  localparam int unsigned PixPerW  = WordW / 16;
  localparam int unsigned PackCntW = $clog2(PixPerW);
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StWrite} state_e;

  state_e                     state_q, state_d;
  logic [WordW-1:0]           mem [FIFO_DEPTH];
  logic [PtrW-1:0]            wptr_q, rptr_q;
  logic [CntW-1:0]            count_q;
  logic [WordW-1:0]           pack_q, pack_d;
  logic [PackCntW-1:0]        pack_cnt_q;
  logic                       pending_q, underflow_q, wrq_q, wready_q;
  logic                       busy_s1_q, busy_s2_q;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;

  logic        fifo_full, fifo_empty, pix_ready, pix_accept, push;
  logic        pop_req, pop, burst_done, clear;
  logic [15:0] rgb565;

  // Datapath control: handshakes, FIFO push/pop and the frame-restart condition.
  always_comb begin
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pix_ready  = !fifo_full && !pending_q;
    pix_accept = bus.i_pix_valid && pix_ready;
    push       = pix_accept && (pack_cnt_q == PackCntW'(PixPerW - 1));
    pop_req    = (state_q == StWrite) && bus.i_mbus_wdata_rq;
    pop        = pop_req && !fifo_empty;
    // Burst completion is the falling edge of the two-stage busy sample.
    burst_done = (state_q == StWrite) && busy_s2_q && !busy_s1_q;
    // A frame start during a burst is deferred to the end of that burst.
    clear      = (bus.i_frame_start && (state_q != StWrite)) ||
                 (burst_done && (pending_q || bus.i_frame_start));
    rgb565     = {bus.i_pix_data[23:19], bus.i_pix_data[15:10], bus.i_pix_data[7:3]};
    pack_d     = pack_q;
    if (pix_accept) begin
      pack_d[pack_cnt_q*16 +: 16] = rgb565;
    end
  end

  // Burst FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q >= CntW'(BURST_NUM)) state_d = StWait;
      StWait:  if (bus.i_mbus_wsel) state_d = StWrite;
      StWrite: if (burst_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
    end
  end

  // Control and status registers.
  always_ff @(posedge i_axi_aclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pending_q   <= 1'b0;
      underflow_q <= 1'b0;
      wrq_q       <= 1'b0;
      wready_q    <= 1'b0;
      busy_s1_q   <= 1'b0;
      busy_s2_q   <= 1'b0;
      addr_q      <= CTRL_ADDR_WIDTH'(START_ADDRESS);
    end else begin
      state_q   <= state_d;
      busy_s1_q <= bus.i_mbus_wbusy;
      busy_s2_q <= busy_s1_q;
      wrq_q     <= (state_q == StWait) && !clear;
      wready_q  <= (state_d != StIdle);
      if (clear) begin
        wptr_q      <= '0;
        rptr_q      <= '0;
        count_q     <= '0;
        pack_q      <= '0;
        pack_cnt_q  <= '0;
        pending_q   <= 1'b0;
        underflow_q <= 1'b0;
        addr_q      <= CTRL_ADDR_WIDTH'(START_ADDRESS);
      end else begin
        pack_q <= pack_d;
        if (pix_accept) pack_cnt_q <= pack_cnt_q + PackCntW'(1);
        if (push) wptr_q <= wptr_q + PtrW'(1);
        if (pop) rptr_q <= rptr_q + PtrW'(1);
        if (push && !pop) count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
        if (pop_req && fifo_empty) underflow_q <= 1'b1;
        if (bus.i_frame_start && (state_q == StWrite)) pending_q <= 1'b1;
        if (burst_done) addr_q <= addr_q + CTRL_ADDR_WIDTH'(ADDR_STEP);
      end
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge i_axi_aclk) begin
    if (push && !clear) begin
      mem[wptr_q] <= pack_d;
    end
  end

  assign bus.o_pix_ready   = pix_ready;
  assign bus.o_mbus_wrq    = wrq_q;
  assign bus.o_mbus_wready = wready_q;
  assign bus.o_mbus_waddr  = addr_q;
  assign bus.o_mbus_wdata  = fifo_empty ? '0 : mem[rptr_q];
  assign bus.o_underflow   = underflow_q;

endmodule

// File: tb/tb_frame_wr_interface.sv
// Scenario bench for frame_wr_interface. START_ADDRESS sits 128 below the top of the
// 28-bit space so the first burst of each frame exercises the address wrap.
module tb_frame_wr_interface;
  localparam logic [27:0] Start = 28'hFFF_FF80;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  frame_wr_if #(.CTRL_ADDR_WIDTH(28), .WDATA_WIDTH(128)) bus ();

  frame_wr_interface #(.START_ADDRESS(32'h0FFF_FF80)) dut (
    .i_axi_aclk (clk),
    .i_rstn     (rstn),
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] expq[$];
  logic [127:0] pack_m;
  int           pack_cnt_m;
  logic [27:0]  addr_m;
  logic         pending_m;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_clear();
    expq.delete();
    pack_m     = '0;
    pack_cnt_m = 0;
    addr_m     = Start;
    pending_m  = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] d);
    int n = 0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = d;
    while (bus.o_pix_ready !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL pix_accept_timeout: o_pix_ready=%b required 1", bus.o_pix_ready);
    end else begin
      pack_m[pack_cnt_m*16 +: 16] = {d[23:19], d[15:10], d[7:3]};
      pack_cnt_m++;
      if (pack_cnt_m == 8) begin expq.push_back(pack_m); pack_cnt_m = 0; end
    end
    step();
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic grant();
    int n = 0;
    while (bus.o_mbus_wrq !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL wrq_timeout: o_mbus_wrq=%b required 1", bus.o_mbus_wrq);
    end
    bus.i_mbus_wsel  = 1'b1;
    bus.i_mbus_wbusy = 1'b1;
    step();
    bus.i_mbus_wsel  = 1'b0;
  endtask

  task automatic pop_words(input int cnt);
    logic [127:0] exp;
    for (int i = 0; i < cnt; i++) begin
      exp = (expq.size() > 0) ? expq[0] : '0;
      checks++;
      if (bus.o_mbus_wdata !== exp) begin
        errors++; $display("FAIL wdata[%0d]: got %h required %h", i, bus.o_mbus_wdata, exp);
      end
      bus.i_mbus_wdata_rq = 1'b1;
      step();
      bus.i_mbus_wdata_rq = 1'b0;
      if (expq.size() > 0) void'(expq.pop_front());
    end
  endtask

  task automatic end_burst();
    int n = 0;
    logic [127:0] exp;
    bus.i_mbus_wbusy = 1'b0;
    while (bus.o_mbus_wready !== 1'b0 && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL burst_end_timeout: o_mbus_wready=%b required 0", bus.o_mbus_wready);
    end
    if (pending_m) model_clear();
    else addr_m = addr_m + 28'd128;
    exp = (expq.size() > 0) ? expq[0] : '0;
    checks++;
    if (bus.o_mbus_waddr !== addr_m) begin
      errors++; $display("FAIL burst_waddr: got %h required %h", bus.o_mbus_waddr, addr_m);
    end
    checks++;
    if (bus.o_mbus_wdata !== exp) begin
      errors++; $display("FAIL burst_wdata_head: got %h required %h", bus.o_mbus_wdata, exp);
    end
    checks++;
    if (bus.o_mbus_wrq !== 1'b0) begin
      errors++; $display("FAIL burst_wrq: got %b required 0", bus.o_mbus_wrq);
    end
  endtask

  task automatic test_reset();
    bus.i_frame_start = 0; bus.i_pix_valid = 0; bus.i_pix_data = '0;
    bus.i_mbus_wdata_rq = 0; bus.i_mbus_wbusy = 0; bus.i_mbus_wsel = 0;
    rstn = 1'b0;
    model_clear();
    repeat (3) step();
    checks++;
    if (bus.o_mbus_waddr !== Start) begin
      errors++; $display("FAIL reset_waddr: got %h required %h", bus.o_mbus_waddr, Start);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (bus.o_mbus_wrq !== 1'b0) begin errors++; $display("FAIL reset_wrq: got %b required 0", bus.o_mbus_wrq); end
    checks++;
    if (bus.o_mbus_wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b required 0", bus.o_mbus_wready); end
    checks++;
    if (bus.o_mbus_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h required 0", bus.o_mbus_wdata); end
    checks++;
    if (bus.o_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b required 0", bus.o_underflow); end
    checks++;
    if (bus.o_pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b required 1", bus.o_pix_ready); end
  endtask

  // 120 red pixels, request timing, one full burst ending in the address wrap.
  task automatic test_fill_burst();
    logic [127:0] red_word;
    red_word = {8{16'hF800}};
    for (int i = 0; i < 120; i++) send_pix(24'hFF0000);
    checks++;
    if (bus.o_mbus_wready !== 1'b0 || bus.o_mbus_wrq !== 1'b0) begin
      errors++; $display("FAIL fill_still_idle: wready=%b wrq=%b required 0 0", bus.o_mbus_wready, bus.o_mbus_wrq);
    end
    step();
    checks++;
    if (bus.o_mbus_wready !== 1'b1 || bus.o_mbus_wrq !== 1'b0) begin
      errors++; $display("FAIL wait_entry: wready=%b wrq=%b required 1 0", bus.o_mbus_wready, bus.o_mbus_wrq);
    end
    step();
    checks++;
    if (bus.o_mbus_wrq !== 1'b1) begin errors++; $display("FAIL wrq_rise: got %b required 1", bus.o_mbus_wrq); end
    checks++;
    if (bus.o_mbus_wdata !== red_word) begin
      errors++; $display("FAIL red_word: got %h required %h", bus.o_mbus_wdata, red_word);
    end
    grant();
    pop_words(15);
    end_burst();
  endtask

  // Frame start arrives mid-burst: held pending, applied when the burst ends.
  task automatic test_frame_start_in_write();
    for (int i = 0; i < 120; i++) send_pix(24'($urandom));
    grant();
    pop_words(5);
    bus.i_frame_start = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
    pending_m = 1'b1;
    checks++;
    if (bus.o_pix_ready !== 1'b0) begin errors++; $display("FAIL pending_pix_ready: got %b required 0", bus.o_pix_ready); end
    checks++;
    if (bus.o_mbus_waddr !== addr_m) begin
      errors++; $display("FAIL pending_waddr: got %h required %h", bus.o_mbus_waddr, addr_m);
    end
    pop_words(5);
    end_burst();
    checks++;
    if (bus.o_pix_ready !== 1'b1) begin errors++; $display("FAIL post_pending_ready: got %b required 1", bus.o_pix_ready); end
  endtask

  // Fill to capacity, back-pressure, drain, underflow, residual discard on frame start.
  task automatic test_full_underflow();
    for (int i = 0; i < 512; i++) send_pix(24'($urandom));
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_pix_ready !== 1'b0) begin errors++; $display("FAIL full_pix_ready[%0d]: got %b required 0", i, bus.o_pix_ready); end
      step();
    end
    bus.i_pix_valid = 1'b0;
    grant();
    pop_words(1);
    checks++;
    if (bus.o_pix_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready: got %b required 1", bus.o_pix_ready); end
    pop_words(63);
    bus.i_mbus_wdata_rq = 1'b1;
    step();
    bus.i_mbus_wdata_rq = 1'b0;
    checks++;
    if (bus.o_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b required 1", bus.o_underflow); end
    checks++;
    if (bus.o_mbus_wdata !== '0) begin errors++; $display("FAIL underflow_wdata: got %h required 0", bus.o_mbus_wdata); end
    end_burst();
    checks++;
    if (bus.o_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b required 1", bus.o_underflow); end
    for (int i = 0; i < 3; i++) send_pix(24'($urandom));
    bus.i_frame_start = 1'b1;
    step();
    bus.i_frame_start = 1'b0;
    model_clear();
    checks++;
    if (bus.o_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b required 0", bus.o_underflow); end
    checks++;
    if (bus.o_mbus_waddr !== Start) begin
      errors++; $display("FAIL fs_waddr: got %h required %h", bus.o_mbus_waddr, Start);
    end
    for (int i = 0; i < 8; i++) send_pix(24'($urandom));
    checks++;
    if (bus.o_mbus_wdata !== expq[0]) begin
      errors++; $display("FAIL residual_discard: got %h required %h", bus.o_mbus_wdata, expq[0]);
    end
  endtask

  // Two bursts back to back: first wraps to 0, second steps to 128.
  task automatic test_back_to_back();
    for (int i = 0; i < 240; i++) send_pix(24'($urandom));
    grant();
    pop_words(15);
    end_burst();
    grant();
    pop_words(15);
    end_burst();
  endtask

  initial begin
    test_reset();
    test_fill_burst();
    test_frame_start_in_write();
    test_full_underflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
